// File: rtl/raycast_pkg.sv
// Shared raycaster types: map cell width, map address sizing and the
// read tag that travels alongside an outstanding map read.
package raycast_pkg;

  localparam int unsigned MAP_DATA_W = 4;
  // Requester id field sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W   = 3;

  // Address width needed to index an side x side map.
  function automatic int unsigned map_addr_w(input int unsigned side);
    return (side * side <= 1) ? 1 : $clog2(side * side);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                map_select;
    logic                oob;
  } map_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational search starting just above the last
// winner, plus the registered last-winner pointer.
//   pixel_clk_in / rst_n_in : clock, async active-low reset
//   req                     : eligible requesters
//   grant_c / grant_valid_c : one-hot grant and "someone won" (combinational)
//   winner_c                : binary index of the winner (combinational)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       pixel_clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic                       grant_valid_c,
  output logic [$clog2(NUM_REQ)-1:0] winner_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;

  // Walk the ring once from last_grant+1, taking the first requester seen.
  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    winner_c      = '0;
    cand          = last_grant;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_valid_c && req[cand]) begin
        grant_valid_c = 1'b1;
        winner_c      = cand;
      end
    end
    if (grant_valid_c) grant_c[winner_c] = 1'b1;
  end

  // Pointer starts at the top so requester 0 wins first after reset.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in)          last_grant <= IDX_W'(NUM_REQ - 1);
    else if (grant_valid_c) last_grant <= winner_c;
  end

endmodule

// File: rtl/map_read_arbiter.sv
// Shares one map BRAM read port among NUM_REQ DDA requesters. One grant per
// cycle, round-robin; a tag pipeline tracks each read so the returned cell is
// steered back to the right requester with a one-cycle valid pulse.
//   pixel_clk_in, rst_n_in        : clock, async active-low reset
//   map_select_in                 : map chosen for a read, sampled at grant
//   req_in, addr_in               : per-requester level request + address
//   data_out, data_valid_out      : per-requester returned cell + pulse
//   map_addra_out                 : shared BRAM address
//   map_data1_in, map_data2_in    : BRAM read data of the two maps
//   busy_out                      : any read outstanding
module map_read_arbiter
  import raycast_pkg::*;
#(
  parameter int unsigned          NUM_REQ      = 2,
  parameter int unsigned          N            = 24,
  parameter int unsigned          READ_LATENCY = 2,
  parameter logic [MAP_DATA_W-1:0] OOB_VALUE   = 4'd1
) (
  input  logic                                pixel_clk_in,
  input  logic                                rst_n_in,
  input  logic                                map_select_in,
  input  logic [NUM_REQ-1:0]                  req_in,
  input  logic [NUM_REQ*map_addr_w(N)-1:0]    addr_in,
  output logic [NUM_REQ*MAP_DATA_W-1:0]       data_out,
  output logic [NUM_REQ-1:0]                  data_valid_out,
  output logic [map_addr_w(N)-1:0]            map_addra_out,
  input  logic [MAP_DATA_W-1:0]               map_data1_in,
  input  logic [MAP_DATA_W-1:0]               map_data2_in,
  output logic                                busy_out
);

  localparam int unsigned ADDR_W     = map_addr_w(N);
  localparam int unsigned IDX_W      = $clog2(NUM_REQ);
  localparam int unsigned TAG_STAGES = READ_LATENCY + 1;
  localparam int unsigned MAP_CELLS  = N * N;

  logic [NUM_REQ-1:0]    pending_q;
  logic [NUM_REQ-1:0]    eligible_c;
  logic [NUM_REQ-1:0]    grant_c;
  logic                  grant_valid_c;
  logic [IDX_W-1:0]      winner_c;
  logic [ADDR_W-1:0]     win_addr_c;
  logic                  win_oob_c;
  map_tag_t              tag_in_c;
  map_tag_t              tag_q [TAG_STAGES];
  map_tag_t              exit_tag_c;
  logic [NUM_REQ-1:0]    clear_c;
  logic [NUM_REQ-1:0]    pending_next_c;
  logic [MAP_DATA_W-1:0] ret_data_c;

  assign eligible_c = req_in & ~pending_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pixel_clk_in  (pixel_clk_in),
    .rst_n_in      (rst_n_in),
    .req           (eligible_c),
    .grant_c       (grant_c),
    .grant_valid_c (grant_valid_c),
    .winner_c      (winner_c)
  );

  // Winner's address and range check.
  always_comb begin
    win_addr_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner_c == IDX_W'(i)) win_addr_c = addr_in[i*ADDR_W +: ADDR_W];
    end
    win_oob_c = 32'(win_addr_c) >= MAP_CELLS;
  end

  always_comb begin
    tag_in_c            = '0;
    tag_in_c.valid      = grant_valid_c;
    tag_in_c.id         = TAG_ID_W'(winner_c);
    tag_in_c.map_select = map_select_in;
    tag_in_c.oob        = win_oob_c;
  end

  // Tag leaving the pipeline lines up with the BRAM data for its address.
  always_comb begin
    exit_tag_c = tag_q[TAG_STAGES-1];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      clear_c[i] = exit_tag_c.valid && (exit_tag_c.id == TAG_ID_W'(i));
    end
    pending_next_c = (pending_q & ~clear_c) | grant_c;
    if (exit_tag_c.oob)             ret_data_c = OOB_VALUE;
    else if (exit_tag_c.map_select) ret_data_c = map_data2_in;
    else                            ret_data_c = map_data1_in;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending_q      <= '0;
      busy_out       <= 1'b0;
      map_addra_out  <= '0;
      data_valid_out <= '0;
      data_out       <= '0;
      for (int unsigned s = 0; s < TAG_STAGES; s++) tag_q[s] <= '0;
    end else begin
      pending_q      <= pending_next_c;
      busy_out       <= |pending_next_c;
      data_valid_out <= clear_c;
      if (grant_valid_c) map_addra_out <= win_oob_c ? '0 : win_addr_c;
      tag_q[0] <= tag_in_c;
      for (int unsigned s = 1; s < TAG_STAGES; s++) tag_q[s] <= tag_q[s-1];
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (clear_c[i]) data_out[i*MAP_DATA_W +: MAP_DATA_W] <= ret_data_c;
      end
    end
  end

endmodule

// File: tb/tb_map_read_arbiter.sv
// Directed bench for map_read_arbiter at default parameters with a
// two-cycle-latency BRAM model holding two synthetic maps.
module tb_map_read_arbiter;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        map_select = 1'b0;
  logic [1:0]  req   = 2'b00;
  logic [19:0] addr  = '0;
  logic [7:0]  data;
  logic [1:0]  dvalid;
  logic [9:0]  map_addra;
  logic [3:0]  d1, d2;
  logic        busy;
  logic [3:0]  p1a = '0, p1b = '0, p2a = '0, p2b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pixel_clk = ~pixel_clk;

  // map1[37] = 3, map1[200] = 13, map1[52] = 1, map1[60] = 9, map1[70] = 2
  function automatic logic [3:0] m1(input logic [9:0] a);
    return 4'(a % 17);
  endfunction
  // map2[37] = 13, map2[100] = 11
  function automatic logic [3:0] m2(input logic [9:0] a);
    return 4'((a % 13) + 2);
  endfunction

  // Two-cycle registered BRAM read.
  always @(posedge pixel_clk) begin
    p1a <= m1(map_addra); p1b <= p1a;
    p2a <= m2(map_addra); p2b <= p2a;
  end
  assign d1 = p1b;
  assign d2 = p2b;

  map_read_arbiter dut (
    .pixel_clk_in   (pixel_clk),
    .rst_n_in       (rst_n),
    .map_select_in  (map_select),
    .req_in         (req),
    .addr_in        (addr),
    .data_out       (data),
    .data_valid_out (dvalid),
    .map_addra_out  (map_addra),
    .map_data1_in   (d1),
    .map_data2_in   (d2),
    .busy_out       (busy)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge pixel_clk); #1; end
  endtask

  task automatic do_reset();
    req = 2'b00; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    n_checks++; if (dvalid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", dvalid); end
    n_checks++; if (map_addra !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", map_addra); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    addr = {10'd0, 10'd37}; map_select = 1'b0; req = 2'b01;
    tick();
    n_checks++; if (map_addra !== 10'd37) begin n_fail++; $display("FAIL single_addr: got %0d expected 37", map_addra); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick(2);
    n_checks++; if (dvalid !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b expected 00", dvalid); end
    tick();
    n_checks++; if (dvalid !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b expected 01", dvalid); end
    n_checks++; if (data[3:0] !== 4'd3) begin n_fail++; $display("FAIL single_data: got %0d expected 3", data[3:0]); end
    req = 2'b00;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    n_checks++; if (dvalid !== 2'b00) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 00", dvalid); end
    n_checks++; if (data[3:0] !== 4'd3) begin n_fail++; $display("FAIL single_hold: got %0d expected 3", data[3:0]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    addr = {10'd200, 10'd37}; req = 2'b11;
    tick();
    n_checks++; if (map_addra !== 10'd37) begin n_fail++; $display("FAIL simul_first: got %0d expected 37", map_addra); end
    tick();
    n_checks++; if (map_addra !== 10'd200) begin n_fail++; $display("FAIL simul_second: got %0d expected 200", map_addra); end
    tick(2);
    n_checks++; if (dvalid !== 2'b01) begin n_fail++; $display("FAIL simul_valid0: got %b expected 01", dvalid); end
    n_checks++; if (data[3:0] !== 4'd3) begin n_fail++; $display("FAIL simul_data0: got %0d expected 3", data[3:0]); end
    req[0] = 1'b0;
    tick();
    n_checks++; if (dvalid !== 2'b10) begin n_fail++; $display("FAIL simul_valid1: got %b expected 10", dvalid); end
    n_checks++; if (data !== {4'd13, 4'd3}) begin n_fail++; $display("FAIL simul_data1: got %h expected d3", data); end
    req[1] = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle: got %b expected 0", busy); end
  endtask

  // After requester 0 alone wins, a contested round goes to requester 1.
  task automatic test_contested_rr();
    addr = {10'd0, 10'd52}; req = 2'b01;
    tick(4);
    n_checks++; if (data[3:0] !== 4'd1) begin n_fail++; $display("FAIL rr_solo_data: got %0d expected 1", data[3:0]); end
    req = 2'b00;
    tick();
    addr = {10'd70, 10'd60}; req = 2'b11;
    tick();
    n_checks++; if (map_addra !== 10'd70) begin n_fail++; $display("FAIL rr_first: got %0d expected 70", map_addra); end
    tick();
    n_checks++; if (map_addra !== 10'd60) begin n_fail++; $display("FAIL rr_second: got %0d expected 60", map_addra); end
    tick(2);
    n_checks++; if (dvalid !== 2'b10 || data[7:4] !== 4'd2) begin n_fail++; $display("FAIL rr_ret1: got %b/%0d expected 10/2", dvalid, data[7:4]); end
    req[1] = 1'b0;
    tick();
    n_checks++; if (dvalid !== 2'b01 || data[3:0] !== 4'd9) begin n_fail++; $display("FAIL rr_ret0: got %b/%0d expected 01/9", dvalid, data[3:0]); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_map_switch();
    addr = {10'd100, 10'd37}; map_select = 1'b0; req = 2'b01;
    tick();
    map_select = 1'b1;
    tick(3);
    n_checks++; if (dvalid !== 2'b01 || data[3:0] !== 4'd3) begin n_fail++; $display("FAIL switch_to2: got %b/%0d expected 01/3", dvalid, data[3:0]); end
    req = 2'b10;
    tick();
    map_select = 1'b0;
    tick(3);
    n_checks++; if (dvalid !== 2'b10 || data[7:4] !== 4'd11) begin n_fail++; $display("FAIL switch_to1: got %b/%0d expected 10/11", dvalid, data[7:4]); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_oob();
    addr = {10'd1023, 10'd576}; map_select = 1'b0; req = 2'b01;
    tick();
    n_checks++; if (map_addra !== 10'd0) begin n_fail++; $display("FAIL oob_addr: got %0d expected 0", map_addra); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL oob_busy: got %b expected 1", busy); end
    tick(2);
    n_checks++; if (dvalid !== 2'b00) begin n_fail++; $display("FAIL oob_early: got %b expected 00", dvalid); end
    tick();
    n_checks++; if (dvalid !== 2'b01 || data[3:0] !== 4'd1) begin n_fail++; $display("FAIL oob_ret: got %b/%0d expected 01/1", dvalid, data[3:0]); end
    map_select = 1'b1; req = 2'b10;
    tick(4);
    n_checks++; if (dvalid !== 2'b10 || data[7:4] !== 4'd1) begin n_fail++; $display("FAIL oob_ret_map2: got %b/%0d expected 10/1", dvalid, data[7:4]); end
    req = 2'b00; map_select = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    addr = {10'd200, 10'd100}; req = 2'b01;
    tick(2);
    rst_n = 1'b0; req = 2'b00; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (map_addra !== 10'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d expected 0", map_addra); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", data); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (dvalid !== 2'b00) begin n_fail++; $display("FAIL rstmid_ghost: cycle %0d got %b expected 00", c, dvalid); end
    end
    req = 2'b10;
    tick();
    n_checks++; if (map_addra !== 10'd200) begin n_fail++; $display("FAIL rstmid_next_addr: got %0d expected 200", map_addra); end
    tick(3);
    n_checks++; if (dvalid !== 2'b10 || data[7:4] !== 4'd13) begin n_fail++; $display("FAIL rstmid_next_ret: got %b/%0d expected 10/13", dvalid, data[7:4]); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_saturation();
    int c0 = 0, c1 = 0, multi = 0, alt_err = 0, data_err = 0, last_id = -1, guard = 0;
    do_reset();
    addr = {10'd200, 10'd37}; map_select = 1'b0; req = 2'b11;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (dvalid == 2'b11) multi++;
      if (dvalid[0]) begin
        c0++;
        if (last_id == 0) alt_err++;
        if (data[3:0] !== 4'd3) data_err++;
        last_id = 0;
      end
      if (dvalid[1]) begin
        c1++;
        if (last_id == 1) alt_err++;
        if (data[7:4] !== 4'd13) data_err++;
        last_id = 1;
      end
    end
    req = 2'b00;
    n_checks++; if (multi !== 0) begin n_fail++; $display("FAIL sat_multi_pulse: got %0d expected 0", multi); end
    n_checks++; if (alt_err !== 0) begin n_fail++; $display("FAIL sat_alternate: got %0d expected 0", alt_err); end
    n_checks++; if (data_err !== 0) begin n_fail++; $display("FAIL sat_data: got %0d expected 0", data_err); end
    n_checks++; if (c0 !== 250) begin n_fail++; $display("FAIL sat_count0: got %0d expected 250", c0); end
    n_checks++; if (c1 !== 249) begin n_fail++; $display("FAIL sat_count1: got %0d expected 249", c1); end
    while (busy && guard < 10) begin tick(); guard++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_drain: got %b expected 0 within 10 cycles", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_contested_rr();
    test_map_switch();
    test_oob();
    test_reset_mid_read();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
